// File: rtl/tx_pkg.sv
// Shared constants for the transmit-path APB register block.
// Holds the register addresses, the CMD and STATUS bit positions, the
// STATUS word layout and the reset values of the WLEN and DIV registers.
package tx_pkg;

  localparam int unsigned ADDR_CTRL   = 0;
  localparam int unsigned ADDR_CMD    = 1;
  localparam int unsigned ADDR_TXDATA = 2;
  localparam int unsigned ADDR_WLEN   = 3;
  localparam int unsigned ADDR_DIV    = 4;
  localparam int unsigned ADDR_STATUS = 5;

  localparam int unsigned CMD_START_BIT = 3;
  localparam int unsigned CMD_STOP_BIT  = 4;

  localparam int unsigned STAT_LEVEL_W   = 6;
  localparam int unsigned STAT_EMPTY_BIT = 6;
  localparam int unsigned STAT_FULL_BIT  = 7;
  localparam int unsigned STAT_BUSY_BIT  = 8;
  localparam int unsigned STAT_UFLOW_BIT = 15;

  localparam logic [7:0]  WLEN_RST = 8'h10;
  localparam logic [15:0] DIV_RST  = 16'h0001;

  // Packed view of STATUS; field order matches the bit positions above.
  typedef struct packed {
    logic                    uflow;
    logic [5:0]              rsvd;
    logic                    busy;
    logic                    full;
    logic                    empty;
    logic [STAT_LEVEL_W-1:0] level;
  } status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_wdata  write one word (ignored when full)
//   i_pop            consume head word (when empty: sets sticky underflow)
//   i_uflow_clr      clear the sticky underflow flag
//   o_rdata          head word; holds the last popped word while empty
//   o_full, o_empty  status flags
//   o_level          number of stored words, 0..DEPTH
//   o_underflow      sticky underflow flag
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_uflow_clr,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_last;
  logic             r_uflow;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push & ~w_full;
  // A pop against an empty FIFO only raises underflow, even if a push lands
  // in the same cycle.
  assign w_do_pop  = i_pop & ~w_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
      r_uflow  <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr[AW-1:0]];
      end
      // Setting wins over a simultaneous clear so no underflow is lost.
      if (i_pop & w_empty) begin
        r_uflow <= 1'b1;
      end else if (i_uflow_clr) begin
        r_uflow <= 1'b0;
      end
    end
  end

  // While empty the slot at the read pointer is stale, so present the word
  // most recently handed out instead.
  assign o_rdata     = w_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_level     = r_wr_ptr - r_rd_ptr;
  assign o_underflow = r_uflow;

endmodule

// File: rtl/apb_tx_regs.sv
// APB slave front-end of the transmit path.
// Decodes APB register accesses, holds CTRL/WLEN/DIV, generates start/stop
// pulses from CMD writes and buffers TXDATA writes in a FIFO that the
// transmitter core drains.
// Ports:
//   PCLK, PRESETn                      clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE/PSELx/PENABLE  APB request
//   PRDATA, PREADY                     APB response
//   ctrl_o, wlen_o, div_o              configuration to the core
//   start_o, stop_o                    one-cycle command pulses
//   tx_pop_i, tx_data_o, tx_empty_o    FIFO drain interface
//   core_busy_i                        core busy, reported in STATUS
module apb_tx_regs
  import tx_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH = 3,
  parameter int unsigned DATAWIDTH    = 16,
  parameter int unsigned FIFO_DEPTH   = 32
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDRESSWIDTH-1:0] PADDR,
  input  logic [DATAWIDTH-1:0]    PWDATA,
  input  logic                    PWRITE,
  input  logic                    PSELx,
  input  logic                    PENABLE,
  output logic [DATAWIDTH-1:0]    PRDATA,
  output logic                    PREADY,
  output logic [7:0]              ctrl_o,
  output logic [7:0]              wlen_o,
  output logic [15:0]             div_o,
  output logic                    start_o,
  output logic                    stop_o,
  input  logic                    tx_pop_i,
  output logic [DATAWIDTH-1:0]    tx_data_o,
  output logic                    tx_empty_o,
  input  logic                    core_busy_i
);

  localparam int unsigned LVLW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]  r_ctrl;
  logic [7:0]  r_wlen;
  logic [15:0] r_div;
  logic        r_start;
  logic        r_stop;

  logic            w_full;
  logic            w_empty;
  logic            w_uflow;
  logic [LVLW-1:0] w_level;
  logic            w_commit;
  logic            w_push;
  logic            w_uflow_clr;
  status_t         w_status;

  logic w_a_ctrl, w_a_cmd, w_a_tx, w_a_wlen, w_a_div, w_a_stat;

  assign w_a_ctrl = (PADDR == ADDRESSWIDTH'(ADDR_CTRL));
  assign w_a_cmd  = (PADDR == ADDRESSWIDTH'(ADDR_CMD));
  assign w_a_tx   = (PADDR == ADDRESSWIDTH'(ADDR_TXDATA));
  assign w_a_wlen = (PADDR == ADDRESSWIDTH'(ADDR_WLEN));
  assign w_a_div  = (PADDR == ADDRESSWIDTH'(ADDR_DIV));
  assign w_a_stat = (PADDR == ADDRESSWIDTH'(ADDR_STATUS));

  // Wait states only for a TXDATA write against a full FIFO.
  assign PREADY      = ~(PSELx & PWRITE & w_a_tx & w_full);
  assign w_commit    = PSELx & PENABLE & PWRITE & PREADY;
  assign w_push      = w_commit & w_a_tx;
  assign w_uflow_clr = w_commit & w_a_stat & PWDATA[STAT_UFLOW_BIT];

  sync_fifo #(
    .WIDTH (DATAWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (PCLK),
    .i_rst_n     (PRESETn),
    .i_push      (w_push),
    .i_pop       (tx_pop_i),
    .i_wdata     (PWDATA),
    .i_uflow_clr (w_uflow_clr),
    .o_rdata     (tx_data_o),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level),
    .o_underflow (w_uflow)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ctrl  <= '0;
      r_wlen  <= WLEN_RST;
      r_div   <= DIV_RST;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      r_start <= w_commit & w_a_cmd & PWDATA[CMD_START_BIT];
      r_stop  <= w_commit & w_a_cmd & PWDATA[CMD_STOP_BIT];
      if (w_commit & w_a_ctrl) r_ctrl <= PWDATA[7:0];
      if (w_commit & w_a_wlen) r_wlen <= PWDATA[7:0];
      if (w_commit & w_a_div)  r_div  <= PWDATA[15:0];
    end
  end

  always_comb begin
    w_status       = '0;
    w_status.level = STAT_LEVEL_W'(w_level);
    w_status.empty = w_empty;
    w_status.full  = w_full;
    w_status.busy  = core_busy_i;
    w_status.uflow = w_uflow;
  end

  always_comb begin
    PRDATA = '0;
    if (PSELx & PENABLE & ~PWRITE) begin
      if (w_a_ctrl)      PRDATA = DATAWIDTH'(r_ctrl);
      else if (w_a_wlen) PRDATA = DATAWIDTH'(r_wlen);
      else if (w_a_div)  PRDATA = DATAWIDTH'(r_div);
      else if (w_a_stat) PRDATA = DATAWIDTH'(w_status);
    end
  end

  assign ctrl_o     = r_ctrl;
  assign wlen_o     = r_wlen;
  assign div_o      = r_div;
  assign start_o    = r_start;
  assign stop_o     = r_stop;
  assign tx_empty_o = w_empty;

endmodule
